// File: rtl/matrix_writeback_sequencer.sv
// Sequences row-by-row write-DMA transfers for one matrix tile descriptor.
// Define WB_SEQ_PERF_EN to build the saturating busy-cycle counter.
module matrix_writeback_sequencer #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int ROW_CNT_WIDTH  = 16
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_base_addr,
   input  logic [31:0]               cmd_row_bytes,
   input  logic [ROW_CNT_WIDTH-1:0]  cmd_num_rows,
   input  logic [31:0]               cmd_row_stride,
   output logic                      dma_start,
   output logic [AXI_ADDR_WIDTH-1:0] dma_start_addr,
   output logic [31:0]               dma_transfer_length,
   input  logic                      dma_done,
   input  logic                      dma_error,
   output logic                      busy,
   output logic                      cmd_done,
   output logic                      cmd_error,
   output logic [ROW_CNT_WIDTH-1:0]  rows_done,
   output logic [31:0]               perf_busy_cycles
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DONE = 2'd1,
      RELEASE   = 2'd2,
      FINISH    = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic                      dma_start_q, dma_start_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               len_q, len_d;
   logic [ROW_CNT_WIDTH-1:0]  num_rows_q, num_rows_d;
   logic [31:0]               stride_q, stride_d;
   logic [ROW_CNT_WIDTH-1:0]  rows_done_q, rows_done_d;
   logic                      err_q, err_d;
   logic                      cmd_done_q, cmd_done_d;
   logic                      cmd_error_q, cmd_error_d;
   logic                      accept_s;

   assign accept_s = (state_q == IDLE) && cmd_valid;

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      dma_start_d = dma_start_q;
      addr_d      = addr_q;
      len_d       = len_q;
      num_rows_d  = num_rows_q;
      stride_d    = stride_q;
      rows_done_d = rows_done_q;
      err_d       = err_q;
      cmd_done_d  = 1'b0;
      cmd_error_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               num_rows_d  = cmd_num_rows;
               stride_d    = cmd_row_stride;
               rows_done_d = '0;
               err_d       = 1'b0;
               addr_d      = cmd_base_addr;
               len_d       = cmd_row_bytes;
               // Empty tiles complete without touching the DMA.
               if ((cmd_num_rows == '0) || (cmd_row_bytes == 32'd0)) begin
                  dma_start_d = 1'b0;
                  cmd_done_d  = 1'b1;
                  state_d     = FINISH;
               end else begin
                  dma_start_d = 1'b1;
                  state_d     = WAIT_DONE;
               end
            end else begin
               dma_start_d = 1'b0;
            end
         end
         WAIT_DONE: begin
            if (dma_done) begin
               dma_start_d = 1'b0;
               rows_done_d = rows_done_q + ROW_CNT_WIDTH'(1'b1);
               err_d       = err_q | dma_error;
               state_d     = RELEASE;
            end else begin
               dma_start_d = 1'b1;
            end
         end
         RELEASE: begin
            // The DMA must drop done before it will accept another start.
            if (!dma_done) begin
               if (!err_q && (rows_done_q < num_rows_q)) begin
                  addr_d      = addr_q + AXI_ADDR_WIDTH'(stride_q);
                  dma_start_d = 1'b1;
                  state_d     = WAIT_DONE;
               end else begin
                  cmd_done_d  = 1'b1;
                  cmd_error_d = err_q;
                  state_d     = FINISH;
               end
            end else begin
               state_d = RELEASE;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            dma_start_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= IDLE;
         dma_start_q <= 1'b0;
         addr_q      <= '0;
         len_q       <= 32'd0;
         num_rows_q  <= '0;
         stride_q    <= 32'd0;
         rows_done_q <= '0;
         err_q       <= 1'b0;
         cmd_done_q  <= 1'b0;
         cmd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dma_start_q <= dma_start_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         num_rows_q  <= num_rows_d;
         stride_q    <= stride_d;
         rows_done_q <= rows_done_d;
         err_q       <= err_d;
         cmd_done_q  <= cmd_done_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   assign cmd_ready           = (state_q == IDLE);
   assign busy                = (state_q != IDLE);
   assign dma_start           = dma_start_q;
   assign dma_start_addr      = addr_q;
   assign dma_transfer_length = len_q;
   assign cmd_done            = cmd_done_q;
   assign cmd_error           = cmd_error_q;
   assign rows_done           = rows_done_q;

`ifdef WB_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   // Saturating busy-cycle counter, restarted by each accepted command.
   always_comb begin
      perf_d = perf_q;
      if (accept_s) begin
         perf_d = 32'd0;
      end else if ((state_q != IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end else begin
         perf_d = perf_q;
      end
   end

   // Busy-cycle counter register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         perf_q <= 32'd0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_busy_cycles = perf_q;
`else
   assign perf_busy_cycles = 32'd0;
`endif

endmodule

// File: doc/matrix_writeback_sequencer.md
MATRIX_WRITEBACK_SEQUENCER -- requirements
Module: matrix_writeback_sequencer

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, the DMA start-address width.
REQ-002 SHALL have parameter ROW_CNT_WIDTH, default 16, the row-count width.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): the command handshake.
REQ-006 SHALL have cmd_base_addr (input, AXI_ADDR_WIDTH), cmd_row_bytes (input, 32), cmd_num_rows (input, ROW_CNT_WIDTH) and cmd_row_stride (input, 32): the tile descriptor.
REQ-007 SHALL have dma_start (output, 1), dma_start_addr (output, AXI_ADDR_WIDTH) and dma_transfer_length (output, 32): the write-DMA control.
REQ-008 SHALL have dma_done (input, 1) and dma_error (input, 1): write-DMA status.
REQ-009 SHALL have busy (output, 1), cmd_done (output, 1-cycle pulse), cmd_error (output, 1-cycle pulse) and rows_done (output, ROW_CNT_WIDTH).
REQ-010 SHALL have perf_busy_cycles (output, 32): busy-cycle counter.

Function
REQ-011 SHALL implement states IDLE, WAIT_DONE, RELEASE and FINISH.
REQ-012 SHALL drive cmd_ready=1 only in IDLE; busy=1 in every other state.
REQ-013 On IDLE with cmd_valid&&cmd_ready, SHALL latch the descriptor, clear rows_done, and register dma_start=1, dma_start_addr=base, dma_transfer_length=row_bytes, then enter WAIT_DONE.
REQ-014 A command with cmd_num_rows=0 or cmd_row_bytes=0 SHALL skip the DMA: no dma_start, enter FINISH directly, and pulse cmd_done one cycle after acceptance.
REQ-015 In WAIT_DONE, SHALL hold dma_start=1 with a stable address and length until dma_done=1.
REQ-016 On dma_done in WAIT_DONE, SHALL register dma_start=0, increment rows_done, sticky-latch dma_error, and enter RELEASE.
REQ-017 In RELEASE, SHALL wait for dma_done=0 before any new dma_start; this is the DMA's done/start release handshake.
REQ-018 On leaving RELEASE with no error and rows_done<num_rows, SHALL add row_stride (zero-extended) to dma_start_addr, modulo 2^AXI_ADDR_WIDTH, assert dma_start, and enter WAIT_DONE.
REQ-019 On leaving RELEASE with an error latched or rows_done==num_rows, SHALL enter FINISH.
REQ-020 An error SHALL abort the remaining rows; rows_done then reports the rows attempted, including the failing row.
REQ-021 FINISH SHALL last exactly one cycle, pulsing cmd_done=1 and cmd_error equal to the latched error, then return to IDLE.
REQ-022 SHALL ignore dma_done and dma_error in IDLE and FINISH.
REQ-023 SHALL ignore cmd_valid while busy; a descriptor is sampled only at acceptance.
REQ-024 rows_done SHALL hold its final value after FINISH until the next command is accepted.

Reset
REQ-025 areset SHALL asynchronously force IDLE, with dma_start, cmd_done, cmd_error, busy, rows_done, dma_start_addr, dma_transfer_length and perf_busy_cycles all 0, and cmd_ready=1.
REQ-026 Reset mid-operation SHALL drop dma_start immediately; the row in flight is abandoned with no cmd_done pulse.

Configuration
REQ-027 With WB_SEQ_PERF_EN defined, perf_busy_cycles SHALL increment, saturating at 0xFFFFFFFF, every cycle busy=1, and clear on command acceptance.
REQ-028 Without WB_SEQ_PERF_EN, perf_busy_cycles SHALL be constant 0 and the counter SHALL not be synthesized.

Verification
REQ-029 Command base=0x1000, row_bytes=64, rows=3, stride=256 with a 1-cycle-done DMA model -> dma_start_addr sequence 0x1000, 0x1100, 0x1200, each length 64; one cmd_done pulse; rows_done=3; cmd_error=0.
REQ-030 rows=2 with dma_error=1 on row 0 -> exactly one dma_start; cmd_done and cmd_error pulse together; rows_done=1.
REQ-031 rows=0 -> dma_start stays 0; cmd_done pulses one cycle after acceptance.
REQ-032 DMA model holds dma_done high 5 cycles after start drops -> next dma_start waits until dma_done=0.
REQ-033 base=0xFFFF_FFFF_FFFF_FF00, stride=0x100, rows=2 -> second address 0x0.
REQ-034 areset pulsed during row 1 of 4 -> dma_start=0 immediately, no cmd_done, cmd_ready=1; a new command then runs normally.
